// File: rtl/dma_pkg.sv
// Shared types and register map for the 8237A program-mode I/O master.
package dma_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } io_state_e;

    typedef enum logic [1:0] {
        PH_CLR,
        PH_LO,
        PH_HI
    } phase_e;

    localparam logic [ADDR_W-1:0] BASE_ADDR_CH0  = 4'h0;
    localparam logic [ADDR_W-1:0] BASE_COUNT_CH0 = 4'h1;
    localparam logic [ADDR_W-1:0] BASE_ADDR_CH1  = 4'h2;
    localparam logic [ADDR_W-1:0] BASE_COUNT_CH1 = 4'h3;
    localparam logic [ADDR_W-1:0] BASE_ADDR_CH2  = 4'h4;
    localparam logic [ADDR_W-1:0] BASE_COUNT_CH2 = 4'h5;
    localparam logic [ADDR_W-1:0] BASE_ADDR_CH3  = 4'h6;
    localparam logic [ADDR_W-1:0] BASE_COUNT_CH3 = 4'h7;
    localparam logic [ADDR_W-1:0] STATUS_ADDR    = 4'h8;
    localparam logic [ADDR_W-1:0] COMMAND_ADDR   = 4'h8;
    localparam logic [ADDR_W-1:0] MODE_ADDR      = 4'hB;
    localparam logic [ADDR_W-1:0] CLR_BP_ADDR    = 4'hC;
    localparam logic [ADDR_W-1:0] MASK_ADDR      = 4'hF;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } byte_cycle_t;

    // Bus payload of one byte cycle for the given phase of a request.
    function automatic byte_cycle_t phase_payload(input phase_e ph, input logic wr,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [2*BYTE_W-1:0] wdata);
        byte_cycle_t c;
        case (ph)
            PH_CLR:  c = '{write: 1'b1, addr: CLR_BP_ADDR, data: 8'h00};
            PH_HI:   c = '{write: wr, addr: addr, data: wdata[15:8]};
            default: c = '{write: wr, addr: addr, data: wdata[7:0]};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dma_io_cycle.sv
// One registered 8237A I/O byte cycle: SETUP, STROBE for STROBE_CYCLES clocks, HOLD.
module dma_io_cycle
    import dma_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [BYTE_W-1:0] db_in,
    output logic              idle_c,
    output logic              strobe_c,
    output logic              done_c,
    output logic [BYTE_W-1:0] rdata,
    output logic              cs_n,
    output logic              ior_n,
    output logic              iow_n,
    output logic [ADDR_W-1:0] addr_l,
    output logic [BYTE_W-1:0] db_out,
    output logic              db_oe
);

    io_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic              cs_n_q, cs_n_d, ior_n_q, ior_n_d, iow_n_q, iow_n_d, oe_q, oe_d;

    assign idle_c   = (state_q == ST_IDLE);
    assign strobe_c = (state_q == ST_STROBE);
    assign done_c   = (state_q == ST_HOLD);

    // Bus pins are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETUP;
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                    state_d = ST_HOLD;
                    rdata_d = db_in;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD:   state_d = start ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (start && (state_q == ST_IDLE || state_q == ST_HOLD)) begin
            wr_d   = write;
            addr_d = addr;
            if (write) dout_d = wdata;
        end
        cs_n_d  = (state_d == ST_IDLE);
        ior_n_d = !((state_d == ST_STROBE) && !wr_d);
        iow_n_d = !((state_d == ST_STROBE) && wr_d);
        oe_d    = (state_d != ST_IDLE) && wr_d;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            ior_n_q <= 1'b1;
            iow_n_q <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            ior_n_q <= ior_n_d;
            iow_n_q <= iow_n_d;
            oe_q    <= oe_d;
        end
    end

    assign rdata  = rdata_q;
    assign cs_n   = cs_n_q;
    assign ior_n  = ior_n_q;
    assign iow_n  = iow_n_q;
    assign addr_l = addr_q;
    assign db_out = dout_q;
    assign db_oe  = oe_q;

endmodule

// File: rtl/dma_cpu_io_master.sv
// Request/response front end that sequences clear-byte-pointer, low and high byte cycles.
module dma_cpu_io_master
    import dma_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter bit          AUTO_CLR_BP   = 1'b1
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_wide,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*BYTE_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [2*BYTE_W-1:0] rsp_rdata,
    output logic                rsp_err,
    input  logic                HLDA,
    output logic                CS_N,
    output logic                IOR_N,
    output logic                IOW_N,
    output logic [ADDR_W-1:0]   ADDR_L,
    output logic [BYTE_W-1:0]   DB_OUT,
    output logic                DB_OE,
    input  logic [BYTE_W-1:0]   DB_IN
);

    phase_e              phase_q, phase_d;
    logic                wide_q, wide_d, write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2*BYTE_W-1:0] wdata_q, wdata_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic                err_q, err_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [2*BYTE_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              io_idle_c, io_strobe_c, io_done_c, start_c, accept_c, more_c;
    logic [BYTE_W-1:0] io_rdata;
    byte_cycle_t       cyc_c;

    assign req_ready = io_idle_c && !HLDA;
    assign accept_c  = req_valid && req_ready;
    assign more_c    = (phase_q == PH_CLR) || ((phase_q == PH_LO) && wide_q);

    // Phase sequencing; the next byte cycle is launched straight out of HOLD so CS_N stays low.
    always_comb begin
        phase_d     = phase_q;
        wide_d      = wide_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        start_c     = 1'b0;
        cyc_c       = '0;
        if (accept_c) begin
            wide_d  = req_wide;
            write_d = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            lo_d    = '0;
            err_d   = 1'b0;
            phase_d = (req_wide && AUTO_CLR_BP) ? PH_CLR : PH_LO;
            start_c = 1'b1;
            cyc_c   = phase_payload(phase_d, req_write, req_addr, req_wdata);
        end else if (io_done_c) begin
            if (phase_q == PH_LO) lo_d = io_rdata;
            if (more_c) begin
                phase_d = (phase_q == PH_CLR) ? PH_LO : PH_HI;
                start_c = 1'b1;
                cyc_c   = phase_payload(phase_d, write_q, addr_q, wdata_q);
            end else begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                if (write_q)                rsp_rdata_d = '0;
                else if (phase_q == PH_HI)  rsp_rdata_d = {io_rdata, lo_q};
                else                        rsp_rdata_d = {8'h00, io_rdata};
            end
        end
        if (io_strobe_c && HLDA) err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_q     <= PH_LO;
            wide_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            phase_q     <= phase_d;
            wide_q      <= wide_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    dma_io_cycle #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_io_cycle (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (start_c),
        .write   (cyc_c.write),
        .addr    (cyc_c.addr),
        .wdata   (cyc_c.data),
        .db_in   (DB_IN),
        .idle_c  (io_idle_c),
        .strobe_c(io_strobe_c),
        .done_c  (io_done_c),
        .rdata   (io_rdata),
        .cs_n    (CS_N),
        .ior_n   (IOR_N),
        .iow_n   (IOW_N),
        .addr_l  (ADDR_L),
        .db_out  (DB_OUT),
        .db_oe   (DB_OE)
    );

endmodule

// File: tb/tb_dma_cpu_io_master.sv
// Scoreboard bench for dma_cpu_io_master: bus-cycle and response expectations queued at issue.
module tb_dma_cpu_io_master;

    localparam int unsigned S = 2;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_wide = 1'b0;
    logic [3:0]  req_addr = 4'h0;
    logic [15:0] req_wdata = 16'h0000;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        HLDA = 1'b0;
    logic        CS_N, IOR_N, IOW_N, DB_OE;
    logic [3:0]  ADDR_L;
    logic [7:0]  DB_OUT;
    logic [7:0]  DB_IN = 8'h00;

    dma_cpu_io_master #(.STROBE_CYCLES(S), .AUTO_CLR_BP(1'b1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HLDA(HLDA), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .ADDR_L(ADDR_L), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DB_IN(DB_IN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] addr;
        logic       wr;
        logic [7:0] data;
    } bus_exp_t;

    typedef struct {
        int          acc;
        int          lat;
        logic        wr;
        logic [15:0] rd;
        logic        err;
    } rsp_exp_t;

    bus_exp_t   exp_bus_q[$];
    rsp_exp_t   exp_rsp_q[$];
    int         exp_cs_q[$];
    logic [7:0] rd_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Bus monitor: protocol invariants, per-strobe payload, strobe and CS_N lengths.
    int sl_cnt = 0, cs_cnt = 0;
    bit prev_sl = 1'b0, prev_csl = 1'b0;
    always @(negedge CLK) begin : bus_mon
        logic     sl;
        bus_exp_t e;
        if (!RESET_N) begin
            sl_cnt = 0; cs_cnt = 0; prev_sl = 1'b0; prev_csl = 1'b0;
        end else begin
            sl = !IOR_N || !IOW_N;
            chk("strobe_overlap", 32'(!IOR_N && !IOW_N), 0);
            chk("cs_high_in_strobe", 32'(CS_N && sl), 0);
            if (sl && !prev_sl) begin
                if (exp_bus_q.size() == 0) fail_now("unexpected_strobe");
                else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_addr", 32'(ADDR_L), 32'(e.addr));
                    chk("bus_is_write", 32'(!IOW_N), 32'(e.wr));
                    chk("bus_oe", 32'(DB_OE), 32'(e.wr));
                    if (e.wr) chk("bus_data", 32'(DB_OUT), 32'(e.data));
                end
            end
            if (sl) sl_cnt++;
            else if (prev_sl) begin
                chk("strobe_len", sl_cnt, S);
                sl_cnt = 0;
            end
            if (!CS_N) cs_cnt++;
            else if (prev_csl) begin
                if (exp_cs_q.size() == 0) fail_now("unexpected_cs_cycle");
                else chk("cs_len", cs_cnt, exp_cs_q.pop_front());
                cs_cnt = 0;
            end
            prev_sl  = sl;
            prev_csl = !CS_N;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid.
    always @(negedge CLK) begin : rsp_mon
        rsp_exp_t r;
        if (RESET_N && rsp_valid) begin
            if (exp_rsp_q.size() == 0) fail_now("unexpected_rsp");
            else begin
                r = exp_rsp_q.pop_front();
                chk("rsp_latency", cyc - 1 - r.acc, r.lat);
                if (!r.wr) chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rd));
                chk("rsp_err", 32'(rsp_err), 32'(r.err));
            end
        end
    end

    // Register-file device: presents the next queued byte, consumed when IOR_N rises.
    bit prev_rd = 1'b0;
    always @(negedge CLK) begin
        if (prev_rd && IOR_N && rd_q.size() != 0) rd_q.delete(0);
        DB_IN   = (rd_q.size() != 0) ? rd_q[0] : 8'h00;
        prev_rd = !IOR_N;
    end

    task automatic issue(input logic wr, input logic wide, input logic [3:0] a,
                         input logic [15:0] wd, input logic [15:0] rd, input logic err,
                         input bit track, output int acc);
        int       n;
        rsp_exp_t r;
        n   = 0;
        acc = -1;
        req_write = wr; req_wide = wide; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 100) begin
            @(negedge CLK); #1; n++;
        end
        if (!req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
        end else begin
            @(posedge CLK);
            acc = cyc;
            #1 req_valid = 1'b0;
            if (wide) begin
                exp_bus_q.push_back('{addr: 4'hC, wr: 1'b1, data: 8'h00});
                exp_bus_q.push_back('{addr: a, wr: wr, data: wd[7:0]});
                exp_bus_q.push_back('{addr: a, wr: wr, data: wd[15:8]});
            end else begin
                exp_bus_q.push_back('{addr: a, wr: wr, data: wd[7:0]});
            end
            if (track) begin
                exp_cs_q.push_back(wide ? 12 : 4);
                r = '{acc: acc, lat: (wide ? 12 : 4), wr: wr, rd: rd, err: err};
                exp_rsp_q.push_back(r);
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || exp_cs_q.size() != 0) && n < 200) begin
            @(negedge CLK); n++;
        end
        chk("drain", exp_rsp_q.size() + exp_cs_q.size(), 0);
        @(negedge CLK);
    endtask

    initial begin : main
        int acc, acc2, drop, n;
        repeat (3) @(negedge CLK);
        chk("rst_cs_n", 32'(CS_N), 1);
        chk("rst_ior_n", 32'(IOR_N), 1);
        chk("rst_iow_n", 32'(IOW_N), 1);
        chk("rst_addr_l", 32'(ADDR_L), 0);
        chk("rst_db_out", 32'(DB_OUT), 0);
        chk("rst_db_oe", 32'(DB_OE), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Narrow write to MODE, wide write to channel 1 base address.
        issue(1'b1, 1'b0, 4'hB, 16'h005A, 16'h0000, 1'b0, 1'b1, acc);
        wait_done();
        issue(1'b1, 1'b1, 4'h2, 16'h1234, 16'h0000, 1'b0, 1'b1, acc);
        wait_done();

        // Narrow status read and wide current-count read.
        rd_q.push_back(8'hA5);
        issue(1'b0, 1'b0, 4'h8, 16'h0000, 16'h00A5, 1'b0, 1'b1, acc);
        wait_done();
        rd_q.push_back(8'h78);
        rd_q.push_back(8'h56);
        issue(1'b0, 1'b1, 4'h7, 16'h0000, 16'h5678, 1'b0, 1'b1, acc);
        wait_done();

        // HLDA blocks acceptance; release is taken on the very next edge.
        HLDA = 1'b1;
        req_write = 1'b1; req_wide = 1'b0; req_addr = 4'hF; req_wdata = 16'h003C;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge CLK); #1;
            chk("hlda_ready_low", 32'(req_ready), 0);
            chk("hlda_cs_high", 32'(CS_N), 1);
        end
        @(negedge CLK);
        HLDA = 1'b0;
        drop = cyc;
        issue(1'b1, 1'b0, 4'hF, 16'h003C, 16'h0000, 1'b0, 1'b1, acc);
        chk("hlda_release_edge", acc, drop);
        wait_done();

        // HLDA pulse during the read strobe flags rsp_err.
        rd_q.push_back(8'h11);
        issue(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0011, 1'b1, 1'b1, acc);
        n = 0;
        while (IOR_N && n < 20) begin
            @(negedge CLK); n++;
        end
        chk("read_strobe_seen", 32'(IOR_N), 0);
        HLDA = 1'b1;
        @(negedge CLK);
        HLDA = 1'b0;
        wait_done();

        // Reset during the low-byte strobe of a wide write drops the transaction.
        issue(1'b1, 1'b1, 4'h3, 16'hABCD, 16'h0000, 1'b0, 1'b0, acc);
        n = 0;
        while (!(!IOW_N && ADDR_L == 4'h3) && n < 40) begin
            @(negedge CLK); n++;
        end
        chk("lo_strobe_seen", 32'(!IOW_N && ADDR_L == 4'h3), 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(CS_N), 1);
        chk("mid_rst_iow_n", 32'(IOW_N), 1);
        chk("mid_rst_db_oe", 32'(DB_OE), 0);
        chk("mid_rst_addr_l", 32'(ADDR_L), 0);
        repeat (2) @(negedge CLK);
        #2 RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("dropped_hi_phase", exp_bus_q.size(), 1);
        exp_bus_q.delete();
        issue(1'b1, 1'b0, 4'hD, 16'h0077, 16'h0000, 1'b0, 1'b1, acc);
        wait_done();

        // Back-to-back: the second request is accepted in the rsp_valid cycle.
        issue(1'b1, 1'b0, 4'h0, 16'h0001, 16'h0000, 1'b0, 1'b1, acc);
        issue(1'b1, 1'b0, 4'h1, 16'h0002, 16'h0000, 1'b0, 1'b1, acc2);
        chk("b2b_gap", acc2 - acc, 5);
        wait_done();

        repeat (3) @(negedge CLK);
        chk("bus_queue_empty", exp_bus_q.size(), 0);
        chk("rd_queue_empty", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
